// File: rtl/cache_refill_unit.sv
// Line-fill engine: fetches one cache line word-by-word from main memory, writes
// each word into the data array, then writes the tag/valid entry and pulses cache_ready.
module cache_refill_unit #(
  parameter int ADDR_WIDTH     = 32,
  parameter int WORD_WIDTH     = 32,
  parameter int WORDS_PER_LINE = 8,
  parameter int IDX_W          = $clog2(WORDS_PER_LINE)
) (
  input  logic                  CLK,
  input  logic                  reset,
  input  logic                  refill,
  input  logic [ADDR_WIDTH-1:0] miss_addr,
  input  logic [WORD_WIDTH-1:0] mem_rdata,
  input  logic                  mem_valid,
  output logic                  mem_rden,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  line_we,
  output logic [IDX_W-1:0]      line_word_idx,
  output logic [WORD_WIDTH-1:0] line_wdata,
  output logic                  tag_we,
  output logic [ADDR_WIDTH-1:0] line_base,
  output logic                  busy,
  output logic                  cache_ready
);

  localparam int LINE_OFF = $clog2(WORDS_PER_LINE * 4);
  localparam logic [ADDR_WIDTH-1:0] OFF_MASK = ADDR_WIDTH'((64'd1 << LINE_OFF) - 64'd1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS_PER_LINE - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t                  state_reg, state_next;
  logic [IDX_W-1:0]        cnt_reg, cnt_next;
  logic [ADDR_WIDTH-1:0]   line_base_reg, line_base_next;
  logic [ADDR_WIDTH-1:0]   word_off;

  always_ff @(posedge CLK) begin
    if (reset) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      line_base_reg <= '0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      line_base_reg <= line_base_next;
    end
  end

  // Byte offset of the current word within the line; wraps modulo 2^ADDR_WIDTH when added.
  assign word_off = {{(ADDR_WIDTH - IDX_W - 2){1'b0}}, cnt_reg, 2'b00};

  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    line_base_next = line_base_reg;
    mem_rden       = 1'b0;
    mem_addr       = '0;
    line_we        = 1'b0;
    line_word_idx  = '0;
    line_wdata     = '0;
    tag_we         = 1'b0;
    busy           = 1'b0;
    cache_ready    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (refill) begin
          line_base_next = miss_addr & ~OFF_MASK;
          cnt_next       = '0;
          state_next     = FETCH;
        end
      end
      FETCH: begin
        busy     = 1'b1;
        mem_rden = 1'b1;
        mem_addr = line_base_reg + word_off;
        // Memory data goes straight through to the data array in the cycle it arrives.
        if (mem_valid) begin
          line_we       = 1'b1;
          line_word_idx = cnt_reg;
          line_wdata    = mem_rdata;
          if (cnt_reg == LAST_IDX) begin
            state_next = DONE;
          end else begin
            cnt_next = cnt_reg + IDX_W'(1);
          end
        end
      end
      DONE: begin
        busy        = 1'b1;
        tag_we      = 1'b1;
        cache_ready = 1'b1;
        state_next  = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign line_base = line_base_reg;

endmodule

// File: tb/tb_cache_refill_unit.sv
// Directed bench for cache_refill_unit: zero-wait, stalled, reset-abort,
// back-to-back and address-wrap fills with hand-computed expectations.
module tb_cache_refill_unit;

  logic        CLK = 1'b0;
  logic        reset;
  logic        refill;
  logic [31:0] miss_addr;
  logic [31:0] mem_rdata;
  logic        mem_valid;
  logic        mem_rden;
  logic [31:0] mem_addr;
  logic        line_we;
  logic [2:0]  line_word_idx;
  logic [31:0] line_wdata;
  logic        tag_we;
  logic [31:0] line_base;
  logic        busy;
  logic        cache_ready;

  int checks = 0;
  int errors = 0;

  cache_refill_unit dut (
    .CLK          (CLK),
    .reset        (reset),
    .refill       (refill),
    .miss_addr    (miss_addr),
    .mem_rdata    (mem_rdata),
    .mem_valid    (mem_valid),
    .mem_rden     (mem_rden),
    .mem_addr     (mem_addr),
    .line_we      (line_we),
    .line_word_idx(line_word_idx),
    .line_wdata   (line_wdata),
    .tag_we       (tag_we),
    .line_base    (line_base),
    .busy         (busy),
    .cache_ready  (cache_ready)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_rden"},  {31'd0, mem_rden}, 32'd0);
    chk({tag, "_addr"},  mem_addr, 32'd0);
    chk({tag, "_we"},    {31'd0, line_we}, 32'd0);
    chk({tag, "_idx"},   {29'd0, line_word_idx}, 32'd0);
    chk({tag, "_wdata"}, line_wdata, 32'd0);
    chk({tag, "_tagwe"}, {31'd0, tag_we}, 32'd0);
    chk({tag, "_busy"},  {31'd0, busy}, 32'd0);
    chk({tag, "_rdy"},   {31'd0, cache_ready}, 32'd0);
  endtask

  initial begin
    int word;
    reset = 1'b1; refill = 1'b0; miss_addr = 32'h0; mem_rdata = 32'h0; mem_valid = 1'b0;
    tick(); tick();

    // Reset state (still in reset)
    @(negedge CLK);
    chk_quiet("rst");
    chk("rst_base", line_base, 32'h0);
    reset = 1'b0;
    tick();

    // Zero-wait fill, with spurious mem_valid in IDLE
    refill = 1'b1; miss_addr = 32'h0000_1234; mem_valid = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    @(negedge CLK);
    chk("idle_spur_we", {31'd0, line_we}, 32'd0);
    chk("idle_busy", {31'd0, busy}, 32'd0);
    tick();
    for (int k = 0; k < 8; k++) begin
      mem_rdata = 32'hA0 + k;
      if (k == 2) miss_addr = 32'hFFFF_FFFC;
      @(negedge CLK);
      $display("zw word %0d addr=%h idx=%0d wdata=%h", k, mem_addr, line_word_idx, line_wdata);
      chk("zw_rden", {31'd0, mem_rden}, 32'd1);
      chk("zw_addr", mem_addr, 32'h1220 + 4 * k);
      chk("zw_we", {31'd0, line_we}, 32'd1);
      chk("zw_idx", {29'd0, line_word_idx}, k);
      chk("zw_wdata", line_wdata, 32'hA0 + k);
      chk("zw_base", line_base, 32'h1220);
      chk("zw_rdy", {31'd0, cache_ready}, 32'd0);
      chk("zw_tagwe", {31'd0, tag_we}, 32'd0);
      tick();
    end
    // DONE (cycle 9), refill still high for back-to-back
    @(negedge CLK);
    chk("zw_done_rdy", {31'd0, cache_ready}, 32'd1);
    chk("zw_done_tagwe", {31'd0, tag_we}, 32'd1);
    chk("zw_done_busy", {31'd0, busy}, 32'd1);
    chk("zw_done_we", {31'd0, line_we}, 32'd0);
    chk("zw_done_rden", {31'd0, mem_rden}, 32'd0);
    tick();
    // Idle gap between fills; new miss address gets latched here
    miss_addr = 32'h0000_5678;
    @(negedge CLK);
    chk("b2b_idle_busy", {31'd0, busy}, 32'd0);
    chk("b2b_idle_rdy", {31'd0, cache_ready}, 32'd0);
    chk("b2b_idle_we", {31'd0, line_we}, 32'd0);
    tick();

    // Stalled fill: mem_valid every 3rd FETCH cycle, refill dropped mid-fill
    refill = 1'b0;
    word = 0;
    for (int c = 0; c < 24; c++) begin
      mem_valid = ((c % 3) == 2);
      mem_rdata = 32'hB0 + word;
      @(negedge CLK);
      $display("stall cyc %0d valid=%0d addr=%h we=%0d", c, mem_valid, mem_addr, line_we);
      chk("st_base", line_base, 32'h5660);
      chk("st_busy", {31'd0, busy}, 32'd1);
      chk("st_addr", mem_addr, 32'h5660 + 4 * word);
      chk("st_we", {31'd0, line_we}, {31'd0, mem_valid});
      chk("st_rdy", {31'd0, cache_ready}, 32'd0);
      if (mem_valid) begin
        chk("st_idx", {29'd0, line_word_idx}, word);
        chk("st_wdata", line_wdata, 32'hB0 + word);
        word++;
      end
      tick();
    end
    mem_valid = 1'b0;
    @(negedge CLK);
    chk("st_done_rdy", {31'd0, cache_ready}, 32'd1);
    chk("st_done_tagwe", {31'd0, tag_we}, 32'd1);
    tick();

    // mem_valid in IDLE without refill: no write, no state change
    mem_valid = 1'b1;
    @(negedge CLK);
    chk("idle2_we", {31'd0, line_we}, 32'd0);
    tick();
    @(negedge CLK);
    chk("idle2_busy", {31'd0, busy}, 32'd0);
    chk("idle2_base", line_base, 32'h5660);

    // Reset mid-fill after word 3 written
    refill = 1'b1; miss_addr = 32'h0000_1000; mem_rdata = 32'hC0;
    tick();
    refill = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge CLK);
      chk("rm_idx", {29'd0, line_word_idx}, k);
      tick();
    end
    reset = 1'b1;
    tick();
    reset = 1'b0; mem_valid = 1'b0;
    @(negedge CLK);
    chk_quiet("rm_abort");
    chk("rm_abort_base", line_base, 32'h0);
    tick();
    @(negedge CLK);
    chk("rm_after_rdy", {31'd0, cache_ready}, 32'd0);
    chk("rm_after_tagwe", {31'd0, tag_we}, 32'd0);
    refill = 1'b1; miss_addr = 32'h0000_2044; mem_valid = 1'b1; mem_rdata = 32'hD0;
    tick();
    @(negedge CLK);
    chk("rm_restart_addr", mem_addr, 32'h2040);
    chk("rm_restart_idx", {29'd0, line_word_idx}, 32'd0);
    refill = 1'b0;
    tick();
    for (int k = 1; k < 8; k++) tick();
    @(negedge CLK);
    chk("rm_restart_rdy", {31'd0, cache_ready}, 32'd1);
    tick();

    // Address wrap
    refill = 1'b1; miss_addr = 32'hFFFF_FFF0;
    tick();
    refill = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge CLK);
      chk("wr_base", line_base, 32'hFFFF_FFE0);
      chk("wr_addr", mem_addr, 32'hFFFF_FFE0 + 4 * k);
      tick();
    end
    mem_valid = 1'b0;
    @(negedge CLK);
    chk("wr_done_rdy", {31'd0, cache_ready}, 32'd1);
    chk("wr_done_addr", mem_addr, 32'h0);
    tick();
    @(negedge CLK);
    chk("wr_idle_busy", {31'd0, busy}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cache_refill_unit.md
Name: cache_refill_unit

Overview:
- Line-fill engine downstream of the cache controller's refill request.
- While the controller holds `refill` high after a miss, this block fetches one full cache line from main memory, one word at a time. It writes each word into the data array, then writes the tag/valid entry.
- It pulses `cache_ready` so the controller can return to COMPARE.

Parameters:
- ADDR_WIDTH, 32, byte address width.
- WORD_WIDTH, 32, data word width. Words are 4 bytes.
- WORDS_PER_LINE, 8, words per cache line. Must be a power of 2 and at least 2.
- IDX_W, $clog2(WORDS_PER_LINE), word index width (derived).

Ports:
- CLK  in  1  clock; all state changes on rising edge.
- reset  in  1  synchronous, active-high reset.
- refill  in  1  refill request from the cache controller. Level; held until `cache_ready`.
- miss_addr  in  ADDR_WIDTH  byte address of the missing access.
- mem_rdata  in  WORD_WIDTH  read data from main memory.
- mem_valid  in  1  `mem_rdata` valid for the current `mem_addr` this cycle.
- mem_rden  out  1  memory read request.
- mem_addr  out  ADDR_WIDTH  word-aligned memory read address.
- line_we  out  1  data-array word write enable.
- line_word_idx  out  IDX_W  word index within the line being written.
- line_wdata  out  WORD_WIDTH  data-array write data.
- tag_we  out  1  tag/valid array write enable. Tag source is `line_base`.
- line_base  out  ADDR_WIDTH  latched line-aligned base address of the fill.
- busy  out  1  fill in progress. High in FETCH and DONE.
- cache_ready  out  1  one-cycle fill-complete pulse.

Behaviour:
- States: IDLE, FETCH, DONE.
- Reset values: state=IDLE, word counter=0, `line_base`=0. All single-bit outputs are 0, `mem_addr`=0, `line_word_idx`=0, `line_wdata`=0.
- Reset mid-fill aborts immediately. The next cycle is IDLE, and no `tag_we` or `cache_ready` is issued for the aborted line.
- IDLE, when `refill`=1:
  - Latch `line_base` = `miss_addr` with the low log2(WORDS_PER_LINE*4) bits cleared.
  - Clear the counter and go to FETCH.
  - Otherwise stay in IDLE.
- FETCH:
  - `mem_rden`=1 and `mem_addr` = `line_base` + counter*4. Both are Moore outputs (state/counter only).
  - The request is held stable until `mem_valid`=1.
  - On `mem_valid`=1, in the same cycle (combinational): `line_we`=1, `line_word_idx`=counter, `line_wdata`=`mem_rdata`.
  - If counter = WORDS_PER_LINE-1, go to DONE. Otherwise increment the counter.
- DONE: `tag_we`=1, `cache_ready`=1 and `busy`=1 for exactly one cycle, then IDLE.
- `refill` is sampled only in IDLE. The cycle after DONE is always IDLE, so a still-high `refill` there starts a new fill on the following edge. The controller drops `refill` on `cache_ready`.
- `mem_valid` outside FETCH is ignored: no writes and no state change.
- Changes to `miss_addr` after latching are ignored until the next IDLE.
- `refill` deasserting during FETCH does not abort; the fill completes.
- Address arithmetic is modulo 2^ADDR_WIDTH. The counter does not wrap within a fill.
- Latency:
  - Zero-wait memory (`mem_valid`=1 every FETCH cycle): `refill` seen at edge 0, FETCH cycles 1..WORDS_PER_LINE, `cache_ready` in cycle WORDS_PER_LINE+1.
  - Each memory stall cycle adds one cycle.
- Exactly WORDS_PER_LINE `line_we` pulses and one `tag_we` per completed fill.

Test Plan:
- Zero-wait fill:
  - Stimulus: `reset`, then `refill`=1 with `miss_addr`=0x0000_1234, `mem_valid` tied 1, `mem_rdata`=0xA0+idx.
  - Response: `line_base`=0x0000_1220 and `mem_addr` sequence 0x1220..0x123C.
  - Response: 8 `line_we` pulses with idx 0..7 and data 0xA0..0xA7, then `tag_we`=`cache_ready`=1 in cycle 9 only.
- Stalled memory:
  - Stimulus: `mem_valid` asserted every 3rd FETCH cycle.
  - Response: `mem_addr` is held constant while `mem_valid`=0, no `line_we` on those cycles, and `cache_ready` arrives 24 cycles after FETCH entry.
- Reset mid-fill:
  - Stimulus: assert `reset` after word 3 is written.
  - Response: the next cycle has all outputs 0 and state IDLE, with no `tag_we` or `cache_ready`.
  - Response: a following `refill` restarts at word 0.
- Spurious and changing inputs:
  - Stimulus: `mem_valid`=1 in IDLE; `miss_addr` changed to 0xFFFF_FFFC during FETCH.
  - Response: no `line_we` in IDLE, and `line_base` is unchanged during the fill.
- Back-to-back fills:
  - Stimulus: `refill` held high through DONE.
  - Response: one idle cycle follows `cache_ready`, then a new fill starts with `line_base` re-latched.
- Address wrap:
  - Stimulus: `miss_addr`=0xFFFF_FFF0.
  - Response: `line_base`=0xFFFF_FFE0, and the last `mem_addr` is 0xFFFF_FFFC with no overflow beyond it.
